// File: rtl/placement_index_pipe.sv
// placement_index_pipe: two-stage placement-coordinate generator.
// Stage 1 looks up the strip's Y base, forms X and the strike causes.
// Stage 2 is the valid/ready output register.
// Optional feature macro: PLACE_IDX_STATS_EN adds the placed/struck counters.
module placement_index_pipe #(
  parameter int ID_W         = 4,
  parameter int COORD_W      = 8,
  parameter int NUM_STRIPS   = 13,
  parameter int GRID_W       = 128,
  parameter int STRIKE_COORD = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ID_W-1:0]    strip_id_in,
  input  logic [COORD_W-1:0] occupied_width_in,
  input  logic [COORD_W-1:0] prog_width_in,
  input  logic               strike_flag_in,
  input  logic               cfg_we,
  input  logic [ID_W-1:0]    cfg_addr,
  input  logic [COORD_W-1:0] cfg_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               strike_out,
`ifdef PLACE_IDX_STATS_EN
  output logic [15:0]        placed_cnt,
  output logic [15:0]        strike_cnt,
`endif
  output logic [2:0]         strike_cause
);

  localparam int                 TAB_N      = 1 << ID_W;
  localparam logic [COORD_W+1:0] GRID_LIM   = (COORD_W+2)'(GRID_W);
  localparam logic [ID_W-1:0]    MAX_ID     = ID_W'(NUM_STRIPS);
  localparam logic [COORD_W-1:0] STRIKE_VAL = COORD_W'(STRIKE_COORD);

  // Power-on Y base for each strip; unlisted strips sit at row 0.
  function automatic logic [COORD_W-1:0] reset_y(input int idx);
    int v;
    case (idx)
      2:       v = 8;
      3:       v = 16;
      4:       v = 25;
      5:       v = 32;
      6:       v = 42;
      7:       v = 48;
      8:       v = 59;
      9:       v = 64;
      10:      v = 76;
      11:      v = 80;
      12:      v = 96;
      13:      v = 112;
      default: v = 0;
    endcase
    return COORD_W'(v);
  endfunction

  logic [COORD_W-1:0] ytab_q [TAB_N];
  logic [COORD_W-1:0] ytab_d [TAB_N];

  logic               s1_valid_q, s1_valid_d;
  logic [COORD_W-1:0] s1_x_q, s1_x_d;
  logic [COORD_W-1:0] s1_y_q, s1_y_d;
  logic [2:0]         s1_cause_q, s1_cause_d;

  logic               out_valid_q, out_valid_d;
  logic [COORD_W-1:0] x_out_q, x_out_d;
  logic [COORD_W-1:0] y_out_q, y_out_d;
  logic               strike_q, strike_d;
  logic [2:0]         cause_q, cause_d;

  logic               s2_load;
  logic [COORD_W+1:0] width_sum;
  logic               bad_id;

  // S2 frees up when empty or draining; S1 may refill whenever it empties or moves on.
  assign s2_load   = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_load;
  assign width_sum = {2'b00, occupied_width_in} + {2'b00, prog_width_in};
  assign bad_id    = (strip_id_in == '0) || (strip_id_in > MAX_ID);

  // Y table update: only real strip IDs are writable.
  always_comb begin
    ytab_d = ytab_q;
    if (cfg_we && (cfg_addr != '0) && (cfg_addr <= MAX_ID)) begin
      ytab_d[cfg_addr] = cfg_data;
    end
  end

  // Stage 1: capture request, table lookup (pre-write value) and cause flags.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_cause_d = s1_cause_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_x_d     = occupied_width_in + COORD_W'(1);
        s1_y_d     = ytab_q[strip_id_in];
        s1_cause_d = {(width_sum > GRID_LIM), bad_id, strike_flag_in};
      end
    end
  end

  // Stage 2: output register, struck requests get the strike coordinate on both axes.
  always_comb begin
    out_valid_d = out_valid_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    strike_d    = strike_q;
    cause_d     = cause_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        cause_d = s1_cause_q;
        if (|s1_cause_q) begin
          x_out_d  = STRIKE_VAL;
          y_out_d  = STRIKE_VAL;
          strike_d = 1'b1;
        end else begin
          x_out_d  = s1_x_q;
          y_out_d  = s1_y_q;
          strike_d = 1'b0;
        end
      end
    end
  end

  // Pipeline and table registers; reset flushes in-flight work and restores the table.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAB_N; i++) begin
        ytab_q[i] <= reset_y(i);
      end
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_cause_q  <= '0;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      strike_q    <= 1'b0;
      cause_q     <= '0;
    end else begin
      ytab_q      <= ytab_d;
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_cause_q  <= s1_cause_d;
      out_valid_q <= out_valid_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      strike_q    <= strike_d;
      cause_q     <= cause_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign x_out        = x_out_q;
  assign y_out        = y_out_q;
  assign strike_out   = strike_q;
  assign strike_cause = cause_q;

`ifdef PLACE_IDX_STATS_EN
  logic [15:0] placed_cnt_q, placed_cnt_d;
  logic [15:0] strike_cnt_q, strike_cnt_d;

  // Count delivered results by outcome, saturating at all-ones.
  always_comb begin
    placed_cnt_d = placed_cnt_q;
    strike_cnt_d = strike_cnt_q;
    if (out_valid_q && out_ready) begin
      if (strike_q) begin
        if (strike_cnt_q != 16'hFFFF) strike_cnt_d = strike_cnt_q + 16'd1;
      end else begin
        if (placed_cnt_q != 16'hFFFF) placed_cnt_d = placed_cnt_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      placed_cnt_q <= '0;
      strike_cnt_q <= '0;
    end else begin
      placed_cnt_q <= placed_cnt_d;
      strike_cnt_q <= strike_cnt_d;
    end
  end

  assign placed_cnt = placed_cnt_q;
  assign strike_cnt = strike_cnt_q;
`endif

endmodule

// File: tb/tb_placement_index_pipe.sv
// Directed-vector bench for placement_index_pipe.
// Results are packed as {out_valid, strike_out, strike_cause, x_out, y_out}.
module tb_placement_index_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] strip_id_in = '0;
  logic [7:0] occupied_width_in = '0;
  logic [7:0] prog_width_in = '0;
  logic       strike_flag_in = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic       strike_out;
  logic [2:0] strike_cause;
`ifdef PLACE_IDX_STATS_EN
  logic [15:0] placed_cnt;
  logic [15:0] strike_cnt;
`endif

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  placement_index_pipe dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .strip_id_in       (strip_id_in),
    .occupied_width_in (occupied_width_in),
    .prog_width_in     (prog_width_in),
    .strike_flag_in    (strike_flag_in),
    .cfg_we            (cfg_we),
    .cfg_addr          (cfg_addr),
    .cfg_data          (cfg_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .x_out             (x_out),
    .y_out             (y_out),
    .strike_out        (strike_out),
`ifdef PLACE_IDX_STATS_EN
    .placed_cnt        (placed_cnt),
    .strike_cnt        (strike_cnt),
`endif
    .strike_cause      (strike_cause)
  );

  function automatic logic [20:0] out_pack();
    return {out_valid, strike_out, strike_cause, x_out, y_out};
  endfunction

  // Present one request for a single accepting edge (pipeline never blocked here).
  task automatic issue(input logic [3:0] id, input logic [7:0] occ, input logic [7:0] prog,
                       input logic ext);
    strip_id_in       = id;
    occupied_width_in = occ;
    prog_width_in     = prog;
    strike_flag_in    = ext;
    in_valid          = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vec_count++;
    if (out_pack() !== 21'd0) begin
      miss_count++;
      $display("[TB] FAIL reset_outputs: got %h want %h", out_pack(), 21'd0);
    end
    vec_count++;
    if (in_ready !== 1'b1) begin
      miss_count++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    end
`ifdef PLACE_IDX_STATS_EN
    vec_count++;
    if ({placed_cnt, strike_cnt} !== 32'd0) begin
      miss_count++;
      $display("[TB] FAIL reset_counters: got %h/%h want 0/0", placed_cnt, strike_cnt);
    end
`endif
  endtask

  task automatic test_basic();
    logic [20:0] exp;
    issue(4'd4, 8'd10, 8'd20, 1'b0);
    @(posedge clk);
    #1;
    exp = {1'b1, 1'b0, 3'b000, 8'd11, 8'd25};
    vec_count++;
    if (out_pack() !== exp) begin
      miss_count++;
      $display("[TB] FAIL basic_strip4: got %h want %h", out_pack(), exp);
    end
  endtask

  task automatic test_bad_id();
    logic [20:0] exp;
    exp = {1'b1, 1'b1, 3'b010, 8'd128, 8'd128};
    issue(4'd0, 8'd5, 8'd5, 1'b0);
    @(posedge clk);
    #1;
    vec_count++;
    if (out_pack() !== exp) begin
      miss_count++;
      $display("[TB] FAIL bad_id_zero: got %h want %h", out_pack(), exp);
    end
    issue(4'd14, 8'd5, 8'd5, 1'b0);
    @(posedge clk);
    #1;
    vec_count++;
    if (out_pack() !== exp) begin
      miss_count++;
      $display("[TB] FAIL bad_id_14: got %h want %h", out_pack(), exp);
    end
  endtask

  task automatic test_overflow();
    logic [20:0] exp;
    issue(4'd2, 8'd100, 8'd28, 1'b0);
    @(posedge clk);
    #1;
    exp = {1'b1, 1'b0, 3'b000, 8'd101, 8'd8};
    vec_count++;
    if (out_pack() !== exp) begin
      miss_count++;
      $display("[TB] FAIL edge_exact_fit: got %h want %h", out_pack(), exp);
    end
    issue(4'd2, 8'd100, 8'd29, 1'b0);
    @(posedge clk);
    #1;
    exp = {1'b1, 1'b1, 3'b100, 8'd128, 8'd128};
    vec_count++;
    if (out_pack() !== exp) begin
      miss_count++;
      $display("[TB] FAIL edge_overflow: got %h want %h", out_pack(), exp);
    end
    issue(4'd0, 8'd200, 8'd100, 1'b1);
    @(posedge clk);
    #1;
    exp = {1'b1, 1'b1, 3'b111, 8'd128, 8'd128};
    vec_count++;
    if (out_pack() !== exp) begin
      miss_count++;
      $display("[TB] FAIL all_causes: got %h want %h", out_pack(), exp);
    end
    issue(4'd1, 8'd255, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    exp = {1'b1, 1'b1, 3'b100, 8'd128, 8'd128};
    vec_count++;
    if (out_pack() !== exp) begin
      miss_count++;
      $display("[TB] FAIL occ_255: got %h want %h", out_pack(), exp);
    end
  endtask

  task automatic test_cfg();
    logic [20:0] exp;
    cfg_we   = 1'b1;
    cfg_addr = 4'd5;
    cfg_data = 8'd50;
    issue(4'd5, 8'd1, 8'd1, 1'b0);
    cfg_we = 1'b0;
    @(posedge clk);
    #1;
    exp = {1'b1, 1'b0, 3'b000, 8'd2, 8'd32};
    vec_count++;
    if (out_pack() !== exp) begin
      miss_count++;
      $display("[TB] FAIL cfg_same_cycle: got %h want %h", out_pack(), exp);
    end
    issue(4'd5, 8'd3, 8'd1, 1'b0);
    cfg_we   = 1'b1;
    cfg_addr = 4'd5;
    cfg_data = 8'd60;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    exp = {1'b1, 1'b0, 3'b000, 8'd4, 8'd50};
    vec_count++;
    if (out_pack() !== exp) begin
      miss_count++;
      $display("[TB] FAIL cfg_new_value: got %h want %h", out_pack(), exp);
    end
    issue(4'd5, 8'd0, 8'd1, 1'b0);
    @(posedge clk);
    #1;
    exp = {1'b1, 1'b0, 3'b000, 8'd1, 8'd60};
    vec_count++;
    if (out_pack() !== exp) begin
      miss_count++;
      $display("[TB] FAIL cfg_inflight_untouched: got %h want %h", out_pack(), exp);
    end
    pulse_reset();
    issue(4'd5, 8'd0, 8'd1, 1'b0);
    @(posedge clk);
    #1;
    exp = {1'b1, 1'b0, 3'b000, 8'd1, 8'd32};
    vec_count++;
    if (out_pack() !== exp) begin
      miss_count++;
      $display("[TB] FAIL cfg_reset_restore: got %h want %h", out_pack(), exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  b_id   [6] = '{4'd1, 4'd3, 4'd13, 4'd15, 4'd7, 4'd9};
    logic [7:0]  b_occ  [6] = '{8'd0, 8'd7, 8'd127, 8'd0, 8'd64, 8'd2};
    logic [7:0]  b_prog [6] = '{8'd1, 8'd3, 8'd1, 8'd0, 8'd65, 8'd2};
    logic        b_ext  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [20:0] b_exp  [6] = '{{1'b1, 1'b0, 3'b000, 8'd1, 8'd0},
                                {1'b1, 1'b0, 3'b000, 8'd8, 8'd16},
                                {1'b1, 1'b0, 3'b000, 8'd128, 8'd112},
                                {1'b1, 1'b1, 3'b010, 8'd128, 8'd128},
                                {1'b1, 1'b1, 3'b100, 8'd128, 8'd128},
                                {1'b1, 1'b1, 3'b001, 8'd128, 8'd128}};
    logic [15:0] pat = 16'b1001_0110_1101_0000;
    logic [20:0] held = '0;
    logic        held_v = 1'b0;
    logic        exp_rdy;
    logic        in_hs;
    int          sent = 0;
    int          recv = 0;
    int          inflight = 0;
    int          cyc = 0;
    int          exp_placed = 0;
    int          exp_struck = 0;
    pulse_reset();
    while (recv < 6 && cyc < 60) begin
      @(negedge clk);
      out_ready = pat[cyc % 16];
      if (sent < 6) begin
        in_valid          = 1'b1;
        strip_id_in       = b_id[sent];
        occupied_width_in = b_occ[sent];
        prog_width_in     = b_prog[sent];
        strike_flag_in    = b_ext[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = !(inflight == 2 && !out_ready);
      vec_count++;
      if (in_ready !== exp_rdy) begin
        miss_count++;
        $display("[TB] FAIL burst_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_rdy);
      end
      if (held_v) begin
        vec_count++;
        if (out_pack() !== held) begin
          miss_count++;
          $display("[TB] FAIL burst_stall_hold cyc %0d: got %h want %h", cyc, out_pack(), held);
        end
      end
      in_hs = in_valid && in_ready;
      if (out_valid && out_ready) begin
        vec_count++;
        if (out_pack() !== b_exp[recv]) begin
          miss_count++;
          $display("[TB] FAIL burst_result %0d: got %h want %h", recv, out_pack(), b_exp[recv]);
        end
        if (b_exp[recv][19]) exp_struck++;
        else exp_placed++;
        recv++;
        inflight--;
        held_v = 1'b0;
      end else if (out_valid) begin
        held   = b_exp[recv];
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (in_hs) begin
        sent++;
        inflight++;
      end
      cyc++;
    end
    if (recv < 6) begin
      vec_count++;
      miss_count++;
      $display("[TB] FAIL burst_timeout: got %0d results want 6", recv);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vec_count++;
    if (out_valid !== 1'b0) begin
      miss_count++;
      $display("[TB] FAIL burst_no_extra: got out_valid %b want 0", out_valid);
    end
`ifdef PLACE_IDX_STATS_EN
    vec_count++;
    if (placed_cnt !== 16'(exp_placed) || strike_cnt !== 16'(exp_struck)) begin
      miss_count++;
      $display("[TB] FAIL burst_counters: got %0d/%0d want %0d/%0d", placed_cnt, strike_cnt,
               exp_placed, exp_struck);
    end
`endif
  endtask

  task automatic test_mid_reset();
    issue(4'd1, 8'd1, 8'd1, 1'b0);
    issue(4'd2, 8'd2, 8'd2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vec_count++;
    if (out_pack() !== 21'd0) begin
      miss_count++;
      $display("[TB] FAIL midreset_flush: got %h want %h", out_pack(), 21'd0);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vec_count++;
      if (out_valid !== 1'b0) begin
        miss_count++;
        $display("[TB] FAIL midreset_stale cyc %0d: got out_valid %b want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_id();
    test_overflow();
    test_cfg();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
